// File: rtl/priority_pkg.sv
// rtl/priority_pkg.sv - shared constants and bit-vector helpers for the priority arbiter family
//
// Contents:
//   DEFAULT_N      default number of request lines
//   MAX_N          widest vector the helper functions accept (callers zero-extend)
//   onehot_to_idx  one-hot vector -> bit index (OR of set-bit indices)
//   popcount       number of set bits in a vector
// These helpers are also used by priority_enc.

package priority_pkg;

    localparam int DEFAULT_N = 8;
    localparam int MAX_N     = 64;

    // OR-reduction encoder: exact for a one-hot input, returns 0 for all-zero.
    function automatic int onehot_to_idx(input logic [MAX_N-1:0] onehot);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (onehot[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

    function automatic int popcount(input logic [MAX_N-1:0] vec);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_N; i++) begin
            cnt = cnt + int'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prio_find_first.sv
// rtl/prio_find_first.sv - combinational lowest-set-bit finder
//
// Parameters:
//   N      vector width (>= 2)
// Ports:
//   vec    input  [N-1:0]  vector to search, bit 0 first
//   found  output          at least one bit of vec is set
//   idx    output [W-1:0]  index of the lowest set bit (0 when found=0)

module prio_find_first
    import priority_pkg::*;
#(
    parameter  int N = DEFAULT_N,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic         found,
    output logic [W-1:0] idx
);

    // Scan from the top down so the last hit written is the lowest set bit.
    always_comb begin
        found = |vec;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/priority_arb.sv
// rtl/priority_arb.sv - registered priority arbiter with valid/ready output handshake
//
// Build option: define PRIORITY_ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority (bit 0 highest) with no pointer state.
//
// Parameters:
//   N            number of request lines (>= 2)
//   IDX_REVERSE  1: out_idx = N-1-winner (legacy encoding), 0: out_idx = winner
// Ports:
//   clk        input           clock, rising edge
//   rst        input           asynchronous active-low reset
//   req        input  [N-1:0]  request vector
//   out_ready  input           consumer accepts the current result
//   out_valid  output          registered result holds at least one request
//   out_idx    output [W-1:0]  encoded winner index
//   out_grant  output [N-1:0]  one-hot winner, zero when out_valid=0
//   out_multi  output          more than one request was set at capture

module priority_arb
    import priority_pkg::*;
#(
    parameter  int N           = DEFAULT_N,
    parameter  int IDX_REVERSE = 1,
    localparam int W           = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_grant,
    output logic         out_multi
);

    logic         load;
    logic         transfer;
    logic         found;
    logic [W-1:0] win;
    logic [W-1:0] idx_enc;

    // A new result may be captured whenever the output slot is empty or is
    // being drained this cycle, giving one result per cycle back to back.
    assign load     = !out_valid || out_ready;
    assign transfer = out_valid && out_ready;

`ifdef PRIORITY_ARB_RR_EN
    logic [W-1:0] ptr;
    logic [W-1:0] ptr_eff;
    logic [W-1:0] held_win;
    logic [W-1:0] held_next;
    logic [N-1:0] masked;
    logic         found_m;
    logic         found_u;
    logic [W-1:0] idx_m;
    logic [W-1:0] idx_u;

    // The winner being handed off is recovered from the registered grant,
    // so no separate raw-index register is needed.
    assign held_win  = W'(onehot_to_idx(MAX_N'(out_grant)));
    assign held_next = (held_win == W'(N - 1)) ? '0 : held_win + 1'b1;

    // The capture that coincides with a transfer must already see the
    // advanced pointer, otherwise a saturated request vector would grant
    // each line twice in a row.
    assign ptr_eff = transfer ? held_next : ptr;
    assign masked  = req & ~((N'(1) << ptr_eff) - N'(1));

    prio_find_first #(.N(N)) u_find_masked (
        .vec   (masked),
        .found (found_m),
        .idx   (idx_m)
    );

    prio_find_first #(.N(N)) u_find_all (
        .vec   (req),
        .found (found_u),
        .idx   (idx_u)
    );

    // Masked hit means a request at or above the pointer; otherwise wrap.
    assign found = found_m | found_u;
    assign win   = found_m ? idx_m : idx_u;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= held_next;
        end
    end
`else
    prio_find_first #(.N(N)) u_find (
        .vec   (req),
        .found (found),
        .idx   (win)
    );
`endif

    assign idx_enc = (IDX_REVERSE != 0) ? (W'(N - 1) - win) : win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_grant <= '0;
            out_multi <= 1'b0;
        end else if (load) begin
            out_valid <= found;
            out_idx   <= found ? idx_enc : '0;
            out_grant <= found ? (N'(1) << win) : '0;
            out_multi <= (popcount(MAX_N'(req)) >= 2);
        end
    end

endmodule

// File: tb/tb_priority_arb.sv
// tb/tb_priority_arb.sv - self-checking bench for priority_arb (N=4 reversed and N=8 plain instances)

module tb_priority_arb;

    logic       clk;
    logic       rst;
    logic [3:0] req4;
    logic       ready4;
    logic       valid4;
    logic [1:0] idx4;
    logic [3:0] grant4;
    logic       multi4;
    logic [7:0] req8;
    logic       ready8;
    logic       valid8;
    logic [2:0] idx8;
    logic [7:0] grant8;
    logic       multi8;

    int checks;
    int errors;

`ifdef PRIORITY_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // Reference state per instance (0: N=4 reversed, 1: N=8 plain).
    int nn [2] = '{4, 8};
    int rv [2] = '{1, 0};
    int m_valid [2];
    int m_win   [2];
    int m_multi [2];
    int m_ptr   [2];

    priority_arb #(.N(4), .IDX_REVERSE(1)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .req       (req4),
        .out_ready (ready4),
        .out_valid (valid4),
        .out_idx   (idx4),
        .out_grant (grant4),
        .out_multi (multi4)
    );

    priority_arb #(.N(8), .IDX_REVERSE(0)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .req       (req8),
        .out_ready (ready8),
        .out_valid (valid8),
        .out_idx   (idx8),
        .out_grant (grant8),
        .out_multi (multi8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 0;
            m_win[d]   = 0;
            m_multi[d] = 0;
            m_ptr[d]   = 0;
        end
    endtask

    // One clock edge of the behavioural model: hand-off advances the pointer,
    // then the search starts at the pointer and walks circularly.
    task automatic model_step(input int d, input int r, input bit rdy);
        bit load;
        bit xfer;
        int start;
        load = (m_valid[d] == 0) || rdy;
        xfer = (m_valid[d] != 0) && rdy;
        if (xfer && RR) m_ptr[d] = (m_win[d] + 1) % nn[d];
        if (load) begin
            if (r == 0) begin
                m_valid[d] = 0;
                m_multi[d] = 0;
            end else begin
                m_valid[d] = 1;
                m_multi[d] = ($countones(r) >= 2) ? 1 : 0;
                start = RR ? m_ptr[d] : 0;
                for (int k = nn[d] - 1; k >= 0; k--) begin
                    if (((r >> ((start + k) % nn[d])) & 1) != 0) m_win[d] = (start + k) % nn[d];
                end
            end
        end
    endtask

    function automatic int exp_idx(input int d);
        if (m_valid[d] == 0) return 0;
        return (rv[d] != 0) ? (nn[d] - 1 - m_win[d]) : m_win[d];
    endfunction

    function automatic int exp_grant(input int d);
        return (m_valid[d] != 0) ? (1 << m_win[d]) : 0;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        req4 = 4'hF; req8 = 8'hFF; ready4 = 1'b0; ready8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({valid4, idx4, grant4, multi4} !== 8'h00) begin
            errors++;
            $display("FAIL reset_n4 got v=%0b idx=%0d grant=%h multi=%0b want all 0", valid4, idx4, grant4, multi4);
        end
        checks++;
        if ({valid8, idx8, grant8, multi8} !== 13'h0) begin
            errors++;
            $display("FAIL reset_n8 got v=%0b idx=%0d grant=%h multi=%0b want all 0", valid8, idx8, grant8, multi8);
        end
        @(negedge clk);
        rst = 1'b1;
        req4 = '0; req8 = '0;
    endtask

    task automatic test_fixed_table();
        logic [3:0] vec  [6] = '{4'b0000, 4'b1000, 4'b0100, 4'b1110, 4'b0001, 4'b1111};
        logic       e_v  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0] e_i  [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        logic [3:0] e_g  [6] = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001};
        logic       e_m  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            rst = 1'b0;
            #1;
            rst = 1'b1;
            req4 = vec[t];
            ready4 = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if ({valid4, idx4, grant4, multi4} !== {e_v[t], e_i[t], e_g[t], e_m[t]}) begin
                errors++;
                $display("FAIL fixed_n4 req=%b got v=%0b idx=%0d grant=%b multi=%0b want v=%0b idx=%0d grant=%b multi=%0b",
                         vec[t], valid4, idx4, grant4, multi4, e_v[t], e_i[t], e_g[t], e_m[t]);
            end
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        rst = 1'b0;
        #1;
        rst = 1'b1;
        req8 = 8'h10;
        ready8 = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({valid8, idx8, grant8} !== {1'b1, 3'd4, 8'h10}) begin
            errors++;
            $display("FAIL stall_capture got v=%0b idx=%0d grant=%h want v=1 idx=4 grant=10", valid8, idx8, grant8);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req8 = 8'h01;
            @(posedge clk);
            #1;
            checks++;
            if ({valid8, idx8, grant8} !== {1'b1, 3'd4, 8'h10}) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got v=%0b idx=%0d grant=%h want v=1 idx=4 grant=10", c, valid8, idx8, grant8);
            end
        end
        @(negedge clk);
        ready8 = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({valid8, idx8, grant8} !== {1'b1, 3'd0, 8'h01}) begin
            errors++;
            $display("FAIL stall_release got v=%0b idx=%0d grant=%h want v=1 idx=0 grant=01", valid8, idx8, grant8);
        end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        rst = 1'b0;
        #1;
        rst = 1'b1;
        req8 = 8'h40;
        ready8 = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({valid8, idx8, grant8} !== {1'b1, 3'd6, 8'h40}) begin
            errors++;
            $display("FAIL midstall_capture got v=%0b idx=%0d grant=%h want v=1 idx=6 grant=40", valid8, idx8, grant8);
        end
        @(negedge clk);
        req8 = 8'h02;
        rst = 1'b0;
        #1;
        checks++;
        if ({valid8, idx8, grant8, multi8} !== 13'h0) begin
            errors++;
            $display("FAIL midstall_async_clear got v=%0b idx=%0d grant=%h multi=%0b want all 0", valid8, idx8, grant8, multi8);
        end
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({valid8, idx8, grant8, multi8} !== {1'b1, 3'd1, 8'h02, 1'b0}) begin
            errors++;
            $display("FAIL midstall_first_capture got v=%0b idx=%0d grant=%h multi=%0b want v=1 idx=1 grant=02 multi=0",
                     valid8, idx8, grant8, multi8);
        end
    endtask

`ifdef PRIORITY_ARB_RR_EN
    task automatic test_round_robin();
        int seq [4] = '{4, 0, 3, 0};
        @(negedge clk);
        rst = 1'b0;
        #1;
        rst = 1'b1;
        req8 = 8'hFF;
        ready8 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (idx8 !== 3'(k % 8) || grant8 !== 8'(1 << (k % 8))) begin
                errors++;
                $display("FAIL rr_sweep step %0d got idx=%0d grant=%h want idx=%0d", k, idx8, grant8, k % 8);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        rst = 1'b1;
        req8 = 8'h10;
        @(posedge clk);
        @(negedge clk);
        req8 = 8'h09;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(posedge clk);
            #1;
            checks++;
            if (idx8 !== 3'(seq[k])) begin
                errors++;
                $display("FAIL rr_wrap step %0d got idx=%0d want %0d", k, idx8, seq[k]);
            end
            if (k == 0) @(negedge clk);
        end
    endtask
`endif

    task automatic test_random();
        @(negedge clk);
        req4 = '0; req8 = '0; ready4 = 1'b1; ready8 = 1'b1;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        model_reset();
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            req4 = 4'($urandom);
            req8 = 8'($urandom);
            if ($urandom_range(0, 7) == 0) req4 = '0;
            if ($urandom_range(0, 7) == 0) req8 = '0;
            ready4 = ($urandom_range(0, 3) != 0);
            ready8 = ($urandom_range(0, 2) != 0);
            model_step(0, int'(req4), ready4);
            model_step(1, int'(req8), ready8);
            @(posedge clk);
            #1;
            checks++;
            if ({valid4, idx4, grant4, multi4} !== {1'(m_valid[0]), 2'(exp_idx(0)), 4'(exp_grant(0)), 1'(m_multi[0])}) begin
                errors++;
                $display("FAIL rand_n4 cycle %0d got v=%0b idx=%0d grant=%b multi=%0b want v=%0d idx=%0d grant=%0h multi=%0d",
                         c, valid4, idx4, grant4, multi4, m_valid[0], exp_idx(0), exp_grant(0), m_multi[0]);
            end
            checks++;
            if ({valid8, idx8, grant8, multi8} !== {1'(m_valid[1]), 3'(exp_idx(1)), 8'(exp_grant(1)), 1'(m_multi[1])}) begin
                errors++;
                $display("FAIL rand_n8 cycle %0d got v=%0b idx=%0d grant=%h multi=%0b want v=%0d idx=%0d grant=%0h multi=%0d",
                         c, valid8, idx8, grant8, multi8, m_valid[1], exp_idx(1), exp_grant(1), m_multi[1]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fixed_table();
        test_stall();
        test_reset_mid_stall();
`ifdef PRIORITY_ARB_RR_EN
        test_round_robin();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
